wb_packer: RTL and testbench

- Writeback stage directly downstream of the convolution/pooling engine.
- Consumes the engine's 16-bit `output_en`/`output_data` result stream and packs BURST_LEN halfwords into one wide word.
- Tags each word with halfword strobes, a write address and a last-word flag.
- Buffers words in a small FIFO for the DMA write path. The engine cannot be stalled, so the FIFO absorbs DMA backpressure and flags loss on overrun.

---
 rtl/wb_packer_pkg.sv | 21 ++
 rtl/wb_packer_if.sv | 14 +
 rtl/wb_fifo.sv | 40 ++++
 rtl/wb_packer.sv | 111 +++++++++++
 tb/tb_wb_packer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_packer_pkg.sv
// rtl/wb_packer_pkg.sv - shared lane geometry and FIFO entry layout for wb_packer
package wb_packer_pkg;
  localparam int BURST_LEN = 8;
  localparam int HW_W      = 16;
  localparam int DATA_W    = HW_W * BURST_LEN;
  localparam int IDX_W     = $clog2(BURST_LEN);

  // FIFO entry = {last, strb, data}
  localparam int DATA_LSB  = 0;
  localparam int STRB_LSB  = DATA_W;
  localparam int LAST_BIT  = DATA_W + BURST_LEN;
  localparam int ENTRY_W   = LAST_BIT + 1;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(input logic last,
                                        input logic [BURST_LEN-1:0] strb,
                                        input logic [DATA_W-1:0] data);
    return {last, strb, data};
  endfunction
endpackage

// File: rtl/wb_packer_if.sv
// rtl/wb_packer_if.sv - packed-word write bus toward the DMA
interface wb_packer_if #(parameter int ADDR_W = 16);
  import wb_packer_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATA_W-1:0]    wr_data;
  logic [BURST_LEN-1:0] wr_strb;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 wr_last;

  modport master (output wr_valid, wr_data, wr_strb, wr_addr, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_strb, wr_addr, wr_last, output wr_ready);
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous show-ahead FIFO; push while full is ignored unless popping
module wb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PTR_W-1:0]] <= din;
  end
endmodule

// File: rtl/wb_packer.sv
// rtl/wb_packer.sv - packs the engine halfword stream into tagged wide words
// and queues them for the DMA write path.
module wb_packer
  import wb_packer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              output_en,
  input  logic [HW_W-1:0]   output_data,
  input  logic              gemm_finish,
  wb_packer_if.master       wr,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       word_count
);
  logic [DATA_W-1:0]    stage_data;
  logic [BURST_LEN-1:0] stage_strb;
  logic [IDX_W-1:0]     idx;
  logic                 gf_q, flush_pending;
  logic                 fin_rise, stage_full, flush_go;
  logic                 push, pop, full, empty;
  logic [ADDR_W-1:0]    addr_q;
  entry_t               push_entry, head;

  assign fin_rise   = gemm_finish & ~gf_q;
  assign stage_full = &stage_strb;
  assign flush_go   = flush_pending & ~output_en & ~op_start;
  // A full stage is held until the next halfword so the final word can carry last=1.
  assign push       = ~op_start & ((output_en & stage_full) | (flush_go & (|stage_strb)));
  assign push_entry = pack_entry(flush_go, stage_strb, stage_data);
  assign pop        = ~empty & wr.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gf_q <= 1'b0;
    else        gf_q <= gemm_finish;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data    <= '0;
      stage_strb    <= '0;
      idx           <= '0;
      flush_pending <= 1'b0;
    end else if (op_start) begin
      stage_data    <= '0;
      stage_strb    <= '0;
      idx           <= '0;
      flush_pending <= 1'b0;
    end else if (output_en) begin
      if (stage_full) begin
        stage_data <= DATA_W'(output_data);
        stage_strb <= BURST_LEN'(1);
        idx        <= IDX_W'(1);
      end else begin
        stage_data[idx*HW_W +: HW_W] <= output_data;
        stage_strb[idx]              <= 1'b1;
        idx                          <= idx + 1'b1;
      end
      if (fin_rise) flush_pending <= 1'b1;
    end else begin
      if (flush_pending) begin
        stage_data <= '0;
        stage_strb <= '0;
        idx        <= '0;
      end
      flush_pending <= fin_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (op_start) begin
      addr_q     <= base_addr;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + 1'b1;
        if (word_count != 16'hFFFF) word_count <= word_count + 1'b1;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Payload is forced to zero while empty so stale RAM never reaches the bus.
  assign wr.wr_valid = ~empty;
  assign wr.wr_data  = empty ? '0 : head[DATA_LSB +: DATA_W];
  assign wr.wr_strb  = empty ? '0 : head[STRB_LSB +: BURST_LEN];
  assign wr.wr_last  = ~empty & head[LAST_BIT];
  assign wr.wr_addr  = addr_q;
  assign busy        = (|stage_strb) | ~empty | flush_pending;
endmodule

// File: tb/tb_wb_packer.sv
// tb/tb_wb_packer.sv - directed vector bench for wb_packer
module tb_wb_packer;
  import wb_packer_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              output_en = 1'b0;
  logic [HW_W-1:0]   output_data = '0;
  logic              gemm_finish = 1'b0;
  logic              busy, overflow;
  logic [15:0]       word_count;

  always #5 clk = ~clk;

  wb_packer_if #(.ADDR_W(ADDR_W)) wr();

  wb_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_start    (op_start),
    .base_addr   (base_addr),
    .output_en   (output_en),
    .output_data (output_data),
    .gemm_finish (gemm_finish),
    .wr          (wr),
    .busy        (busy),
    .overflow    (overflow),
    .word_count  (word_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
    logic [BURST_LEN-1:0] strb;
    logic                 last;
  } cap_t;

  cap_t         cap_q[$];
  logic         mon_en = 1'b0;
  logic         prev_stall = 1'b0;
  logic [255:0] prev_pl = '0;

  always @(negedge clk) begin
    cap_t c;
    if (mon_en) begin
      if (prev_stall)
        check("stall_stable", {wr.wr_valid, wr.wr_last, wr.wr_strb, wr.wr_addr, wr.wr_data},
              {1'b1, prev_pl[152:0]});
      if (wr.wr_valid && wr.wr_ready) begin
        c.addr = wr.wr_addr; c.data = wr.wr_data; c.strb = wr.wr_strb; c.last = wr.wr_last;
        cap_q.push_back(c);
      end
      prev_stall = wr.wr_valid && !wr.wr_ready;
      prev_pl    = 256'({wr.wr_last, wr.wr_strb, wr.wr_addr, wr.wr_data});
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    op_start = 1'b1; base_addr = b;
    tick();
    op_start = 1'b0;
  endtask

  typedef struct {
    int                   n_hw;
    logic [15:0]          first;
    logic [15:0]          step;
    logic                 coincide;
    logic                 toggle;
    int                   exp_words;
    logic [BURST_LEN-1:0] exp_last_strb;
    logic [ADDR_W-1:0]    base;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k, input vec_t v);
    logic [DATA_W-1:0]    ed;
    logic [BURST_LEN-1:0] es;
    int                   h, n;
    cap_q.delete();
    wr.wr_ready = 1'b1;
    do_start(v.base);
    mon_en = 1'b1;
    for (int i = 0; i < v.n_hw; i++) begin
      output_en   = 1'b1;
      output_data = 16'(v.first + v.step * i);
      gemm_finish = v.coincide && (i == v.n_hw - 1);
      if (v.toggle) wr.wr_ready = (i % 2) == 1;
      tick();
    end
    output_en = 1'b0;
    if (!v.coincide) begin
      gemm_finish = 1'b1;
      tick();
    end
    gemm_finish = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (v.toggle) wr.wr_ready = ~wr.wr_ready;
      tick();
    end
    wr.wr_ready = 1'b1;
    tick();
    mon_en = 1'b0;
    check($sformatf("v%0d_nwords", k), cap_q.size(), v.exp_words);
    n = (cap_q.size() < v.exp_words) ? cap_q.size() : v.exp_words;
    for (int j = 0; j < n; j++) begin
      ed = '0;
      for (int l = 0; l < BURST_LEN; l++) begin
        h = j * BURST_LEN + l;
        if (h < v.n_hw) ed[l*HW_W +: HW_W] = 16'(v.first + v.step * h);
      end
      es = (j == v.exp_words - 1) ? v.exp_last_strb : {BURST_LEN{1'b1}};
      check($sformatf("v%0d_w%0d_addr", k, j), cap_q[j].addr, ADDR_W'(v.base + j));
      check($sformatf("v%0d_w%0d_data", k, j), cap_q[j].data, ed);
      check($sformatf("v%0d_w%0d_strb", k, j), cap_q[j].strb, es);
      check($sformatf("v%0d_w%0d_last", k, j), cap_q[j].last, j == v.exp_words - 1);
    end
    check($sformatf("v%0d_word_count", k), word_count, v.exp_words);
    check($sformatf("v%0d_busy", k), busy, 1'b0);
    check($sformatf("v%0d_overflow", k), overflow, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] ed;
    wr.wr_ready = 1'b0;

    vecs[0] = '{16, 16'h0001, 16'h0001, 1'b0, 1'b0, 2, 8'hFF, 16'h0100};
    vecs[1] = '{3,  16'hAAAA, 16'h1111, 1'b0, 1'b0, 1, 8'h07, 16'h0010};
    vecs[2] = '{8,  16'h8000, 16'h0003, 1'b1, 1'b0, 1, 8'hFF, 16'h0020};
    vecs[3] = '{0,  16'h0000, 16'h0000, 1'b0, 1'b0, 0, 8'h00, 16'h0030};
    vecs[4] = '{32, 16'h1234, 16'h0101, 1'b0, 1'b1, 4, 8'hFF, 16'hFFFE};
    vecs[5] = '{9,  16'h7000, 16'h0001, 1'b0, 1'b0, 2, 8'h01, 16'h0040};

    tick(); tick();
    check("rst_valid", wr.wr_valid, 1'b0);
    check("rst_data", {wr.wr_last, wr.wr_strb, wr.wr_data}, '0);
    check("rst_addr", wr.wr_addr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_word_count", word_count, '0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Overflow: 16 words fill the FIFO, the 17th push (halfword 137) is dropped.
    wr.wr_ready = 1'b0;
    do_start(16'h0200);
    for (int i = 1; i <= 144; i++) begin
      output_en = 1'b1; output_data = 16'(i);
      tick();
      if (i == 136) begin
        output_en = 1'b0;
        tick();
        check("ovf_before", overflow, 1'b0);
        check("ovf_full_valid", wr.wr_valid, 1'b1);
      end
    end
    output_en = 1'b0;
    tick();
    check("ovf_after", overflow, 1'b1);
    cap_q.delete();
    mon_en = 1'b1;
    tick();
    wr.wr_ready = 1'b1;
    repeat (22) tick();
    mon_en = 1'b0;
    check("ovf_nwords", cap_q.size(), 16);
    for (int j = 0; j < 16 && j < cap_q.size(); j++) begin
      for (int l = 0; l < BURST_LEN; l++) ed[l*HW_W +: HW_W] = 16'(j * BURST_LEN + l + 1);
      check($sformatf("ovf_w%0d_addr", j), cap_q[j].addr, 16'h0200 + j);
      check($sformatf("ovf_w%0d_data", j), cap_q[j].data, ed);
      check($sformatf("ovf_w%0d_last", j), cap_q[j].last, 1'b0);
    end
    check("ovf_sticky", overflow, 1'b1);
    do_start(16'h0000);
    check("ovf_cleared", overflow, 1'b0);
    check("ovf_busy_after_start", busy, 1'b0);

    // Reset mid-stream with 2 words queued and 5 halfwords staged.
    wr.wr_ready = 1'b0;
    do_start(16'h0300);
    for (int i = 0; i < 21; i++) begin
      output_en = 1'b1; output_data = 16'h5000 + 16'(i);
      tick();
    end
    output_en = 1'b0;
    tick();
    check("mid_valid_before", wr.wr_valid, 1'b1);
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_in_reset", wr.wr_valid, 1'b0);
    check("mid_busy_in_reset", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    wr.wr_ready = 1'b1;
    cap_q.delete();
    mon_en = 1'b1;
    repeat (12) tick();
    mon_en = 1'b0;
    check("mid_no_words", cap_q.size(), 0);
    check("mid_valid_after", wr.wr_valid, 1'b0);
    run_vec(6, vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
